easyaxi_sim_ctrl: RTL and testbench

- Synthesizable run controller for EASYAXI top-level simulations and FPGA self-test builds.
- Sequences the start of traffic after reset, then watches a configurable number of DUT channels for error or completion.
- Enforces a timeout watchdog and a post-error drain window, then reports a latched pass/fail verdict.
- Generalises the single-enable/single-error bench flow to CH_NUM channels, adding per-channel completion, timeout detection and fail codes.

---
 rtl/easyaxi_sim_ctrl_if.sv | 36 +++
 rtl/easyaxi_sim_ctrl.sv | 146 ++++++++++++++
 tb/tb_easyaxi_sim_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/easyaxi_sim_ctrl_if.sv
// rtl/easyaxi_sim_ctrl_if.sv - channel enable/status bundle between the run controller and the DUT harness
interface easyaxi_sim_ctrl_if #(
  parameter int CH_NUM = 2,
  parameter int CNT_W  = 16
);
  logic [CH_NUM-1:0] ch_error;
  logic [CH_NUM-1:0] ch_done;
  logic [CH_NUM-1:0] enable;
  logic              finish;
  logic              pass;
  logic [1:0]        fail_code;
  logic [CH_NUM-1:0] err_ch;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    input  ch_error,
    input  ch_done,
    output enable,
    output finish,
    output pass,
    output fail_code,
    output err_ch,
    output cycle_cnt
  );

  modport slave (
    output ch_error,
    output ch_done,
    input  enable,
    input  finish,
    input  pass,
    input  fail_code,
    input  err_ch,
    input  cycle_cnt
  );
endinterface

// File: rtl/easyaxi_sim_ctrl.sv
// rtl/easyaxi_sim_ctrl.sv - run controller: start delay, per-channel enable, watchdog, drain and latched verdict
module easyaxi_sim_ctrl #(
  parameter int CH_NUM    = 2,
  parameter int START_DLY = 5,
  parameter int DRAIN_DLY = 20,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  easyaxi_sim_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [1:0]       FC_NONE    = 2'd0;
  localparam logic [1:0]       FC_ERR     = 2'd1;
  localparam logic [1:0]       FC_TMO     = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_DLY - 1);

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CH_NUM-1:0] enable_q,    enable_d;
  logic [CH_NUM-1:0] done_stk_q,  done_stk_d;
  logic [CH_NUM-1:0] err_ch_q,    err_ch_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic              finish_q,    finish_d;
  logic              pass_q,      pass_d;
  logic              run_exit;

  // cnt is shared: start delay in WAIT, watchdog in RUN, drain length in DRAIN
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    enable_d    = enable_q;
    done_stk_d  = done_stk_q;
    err_ch_d    = err_ch_q;
    fail_code_d = fail_code_q;
    finish_d    = finish_q;
    pass_d      = pass_q;
    run_exit    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          enable_d = '1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cnt_d      = cnt_q + CNT_ONE;
        done_stk_d = done_stk_q | bus.ch_done;
        enable_d   = ~done_stk_d;
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end
        // error outranks completion, completion outranks the watchdog
        if (|bus.ch_error) begin
          err_ch_d    = err_ch_q | bus.ch_error;
          fail_code_d = FC_ERR;
          run_exit    = 1'b1;
        end else if (&done_stk_d) begin
          fail_code_d = FC_NONE;
          run_exit    = 1'b1;
        end else if (cnt_q == RUN_LAST) begin
          fail_code_d = FC_TMO;
          run_exit    = 1'b1;
        end
        if (run_exit) begin
          state_d  = ST_DRAIN;
          cnt_d    = '0;
          enable_d = '0;
        end
      end

      ST_DRAIN: begin
        enable_d = '0;
        err_ch_d = err_ch_q | bus.ch_error;
        if ((|bus.ch_error) && (fail_code_q == FC_NONE)) begin
          fail_code_d = FC_ERR;
        end
        if (cnt_q == DRAIN_LAST) begin
          state_d  = ST_END;
          finish_d = 1'b1;
          pass_d   = (fail_code_d == FC_NONE);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_END: begin
        enable_d = '0;
      end

      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      cycle_cnt_q <= '0;
      enable_q    <= '0;
      done_stk_q  <= '0;
      err_ch_q    <= '0;
      fail_code_q <= FC_NONE;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      enable_q    <= enable_d;
      done_stk_q  <= done_stk_d;
      err_ch_q    <= err_ch_d;
      fail_code_q <= fail_code_d;
      finish_q    <= finish_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.enable    = enable_q;
  assign bus.finish    = finish_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = fail_code_q;
  assign bus.err_ch    = err_ch_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_easyaxi_sim_ctrl.sv
// tb/tb_easyaxi_sim_ctrl.sv - directed vector bench for easyaxi_sim_ctrl
module tb_easyaxi_sim_ctrl;
  localparam int CH   = 2;
  localparam int CW   = 16;
  localparam int NONE = -10000;
  localparam int NV   = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  easyaxi_sim_ctrl_if #(.CH_NUM(CH), .CNT_W(CW)) bus ();

  easyaxi_sim_ctrl #(
    .CH_NUM   (CH),
    .START_DLY(5),
    .DRAIN_DLY(20),
    .TIMEOUT  (1000),
    .CNT_W    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // d0/d1/ec are RUN cycle numbers, dj is a DRAIN cycle number, wn drives noise during WAIT
  typedef struct {
    int         d0;
    int         d1;
    int         ec;
    logic [1:0] eb;
    int         dj;
    logic [1:0] db;
    bit         wn;
    logic [1:0] xc;
    logic       xp;
    logic [1:0] xe;
    int         xn;
  } vec_t;

  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;
  int   gcyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    gcyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.ch_error = '0;
    bus.ch_done  = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gcyc  = 0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   fin_g;
    int   k;
    int   j;
    v     = vecs[i];
    fin_g = 25 + v.xn;
    apply_reset();
    while (gcyc <= fin_g) begin
      k = gcyc - 5;
      j = gcyc - 5 - v.xn;
      bus.ch_done  = '0;
      bus.ch_error = '0;
      if (v.wn && gcyc < 5) begin
        bus.ch_done  = '1;
        bus.ch_error = '1;
      end
      if (k == v.d0) bus.ch_done[0] = 1'b1;
      if (k == v.d1) bus.ch_done[1] = 1'b1;
      if (k == v.ec) bus.ch_error = bus.ch_error | v.eb;
      if (j == v.dj) bus.ch_error = bus.ch_error | v.db;
      if (gcyc == fin_g - 1) chk($sformatf("v%0d_finish_early", i), 32'(bus.finish), 32'd0);
      if (gcyc == fin_g) begin
        chk($sformatf("v%0d_finish", i), 32'(bus.finish), 32'd1);
        chk($sformatf("v%0d_pass", i), 32'(bus.pass), 32'(v.xp));
        chk($sformatf("v%0d_fail_code", i), 32'(bus.fail_code), 32'(v.xc));
        chk($sformatf("v%0d_err_ch", i), 32'(bus.err_ch), 32'(v.xe));
        chk($sformatf("v%0d_cycle_cnt", i), 32'(bus.cycle_cnt), 32'(v.xn));
        break;
      end
      tick();
    end
    bus.ch_done  = '0;
    bus.ch_error = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

  initial begin
    //            d0    d1    ec    eb     dj    db     wn    xc     xp    xe     xn
    vecs[0] = '{40,   60,   NONE, 2'b00, NONE, 2'b00, 1'b0, 2'd0, 1'b1, 2'b00, 61};
    vecs[1] = '{NONE, NONE, 30,   2'b01, NONE, 2'b00, 1'b0, 2'd1, 1'b0, 2'b01, 31};
    vecs[2] = '{NONE, NONE, NONE, 2'b00, NONE, 2'b00, 1'b0, 2'd2, 1'b0, 2'b00, 1000};
    vecs[3] = '{25,   25,   25,   2'b10, 3,    2'b01, 1'b0, 2'd1, 1'b0, 2'b11, 26};
    vecs[4] = '{NONE, NONE, NONE, 2'b00, 5,    2'b10, 1'b0, 2'd2, 1'b0, 2'b10, 1000};
    vecs[5] = '{15,   15,   NONE, 2'b00, 19,   2'b10, 1'b0, 2'd1, 1'b0, 2'b10, 16};
    vecs[6] = '{10,   10,   NONE, 2'b00, NONE, 2'b00, 1'b1, 2'd0, 1'b1, 2'b00, 11};
    vecs[7] = '{10,   NONE, 20,   2'b01, NONE, 2'b00, 1'b0, 2'd1, 1'b0, 2'b01, 21};
    vecs[8] = '{50,   50,   NONE, 2'b00, 10,   2'b01, 1'b0, 2'd1, 1'b0, 2'b01, 51};

    // reset values and enable timing around per-channel completion
    bus.ch_error = '0;
    bus.ch_done  = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_finish", 32'(bus.finish), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_fail_code", 32'(bus.fail_code), 32'd0);
    chk("rst_err_ch", 32'(bus.err_ch), 32'd0);
    chk("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    rst_n = 1'b1;
    gcyc  = 0;
    while (gcyc <= 66) begin
      bus.ch_done = '0;
      if (gcyc == 45) bus.ch_done = 2'b01;
      if (gcyc == 65) bus.ch_done = 2'b10;
      if (gcyc == 4)  chk("en_wait_last", 32'(bus.enable), 32'b00);
      if (gcyc == 5)  chk("en_rise", 32'(bus.enable), 32'b11);
      if (gcyc == 45) chk("en_before_done0", 32'(bus.enable), 32'b11);
      if (gcyc == 46) chk("en_after_done0", 32'(bus.enable), 32'b10);
      if (gcyc == 66) chk("en_after_all_done", 32'(bus.enable), 32'b00);
      tick();
    end
    bus.ch_done = '0;

    // error drops every enable on the following cycle
    apply_reset();
    while (gcyc <= 36) begin
      bus.ch_error = (gcyc == 35) ? 2'b01 : 2'b00;
      if (gcyc == 35) chk("err_en_before", 32'(bus.enable), 32'b11);
      if (gcyc == 36) begin
        chk("err_en_after", 32'(bus.enable), 32'b00);
        chk("err_err_ch", 32'(bus.err_ch), 32'b01);
        chk("err_fail_code", 32'(bus.fail_code), 32'd1);
        chk("err_no_finish", 32'(bus.finish), 32'd0);
      end
      tick();
    end
    bus.ch_error = '0;

    // asynchronous reset in the middle of RUN
    apply_reset();
    while (gcyc < 105) tick();
    chk("mid_cycle_cnt", 32'(bus.cycle_cnt), 32'd100);
    chk("mid_enable", 32'(bus.enable), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_enable", 32'(bus.enable), 32'd0);
    chk("arst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("arst_fail_code", 32'(bus.fail_code), 32'd0);
    chk("arst_finish", 32'(bus.finish), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gcyc  = 0;
    while (gcyc <= 6) begin
      if (gcyc == 4) chk("rerun_en_wait", 32'(bus.enable), 32'b00);
      if (gcyc == 5) begin
        chk("rerun_en_rise", 32'(bus.enable), 32'b11);
        chk("rerun_cnt0", 32'(bus.cycle_cnt), 32'd0);
      end
      if (gcyc == 6) chk("rerun_cnt1", 32'(bus.cycle_cnt), 32'd1);
      tick();
    end

    for (int i = 0; i < NV; i++) run_vec(i);

    // END ignores all further channel activity
    bus.ch_error = '1;
    bus.ch_done  = '1;
    tick();
    tick();
    tick();
    bus.ch_error = '0;
    bus.ch_done  = '0;
    chk("post_finish", 32'(bus.finish), 32'd1);
    chk("post_pass", 32'(bus.pass), 32'd0);
    chk("post_fail_code", 32'(bus.fail_code), 32'd1);
    chk("post_err_ch", 32'(bus.err_ch), 32'b01);
    chk("post_cycle_cnt", 32'(bus.cycle_cnt), 32'd51);
    chk("post_enable", 32'(bus.enable), 32'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
